// File: rtl/register_file_pkg.sv
// Shared sizing and address types for the register file and its scoreboard.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding.
package register_file_pkg;
  localparam int WORD_SIZE = 32;
  localparam int NUM_REGS  = 32;
  localparam int ADDR_W    = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;
endpackage

// File: rtl/register_file_scoreboard.sv
// Busy-bit scoreboard with RAW/WAW stall detection.
// Bypass matches come from the parent so forwarding stays a build option.
module reg_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       alloc_valid_i,
  input  logic [4:0] rd_alloc_i,
  input  logic       wr_en_i,
  input  logic [4:0] wr_addr_i,
  input  logic       byp1_i,
  input  logic       byp2_i,
  output logic       stall_o
);
  import register_file_pkg::*;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic wb_live, wb_rd, raw, waw;

  always_comb begin
    wb_live = wr_en_i && (wr_addr_i != X0);
    wb_rd   = wb_live && (wr_addr_i == rd_alloc_i);
    raw     = (busy_q[rs1_i] && !byp1_i)
           || (busy_q[rs2_i] && !byp2_i);
    waw     = alloc_valid_i && busy_q[rd_alloc_i] && !wb_rd;
    stall_o = raw || waw;

    busy_d = busy_q;
    if (wb_live)
      busy_d[wr_addr_i] = 1'b0;
    // Set after clear so a new alloc wins over a same-cycle writeback.
    if (alloc_valid_i && !stall_o && (rd_alloc_i != X0))
      busy_d[rd_alloc_i] = 1'b1;
    busy_d[X0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end
endmodule

// File: rtl/register_file.sv
// Register file with combinational reads and a busy-bit scoreboard.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writeback to reads.
module register_file #(
  parameter int WORD_SIZE = register_file_pkg::WORD_SIZE,
  parameter int NUM_REGS  = register_file_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [WORD_SIZE-1:0] rd1_data,
  output logic [WORD_SIZE-1:0] rd2_data,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 alloc_valid,
  input  logic [4:0]           rd_alloc,
  output logic                 stall
);
  import register_file_pkg::*;

  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic byp1, byp2;

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_en && (wr_addr != X0) && (wr_addr == rs1);
  assign byp2 = wr_en && (wr_addr != X0) && (wr_addr == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (wr_en && (wr_addr != X0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd1_data = byp1 ? wr_data : regs_q[rs1];
    rd2_data = byp2 ? wr_data : regs_q[rs2];
    if (rs1 == X0) rd1_data = '0;
    if (rs2 == X0) rd2_data = '0;
  end

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .alloc_valid_i(alloc_valid),
    .rd_alloc_i   (rd_alloc),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .byp1_i       (byp1),
    .byp2_i       (byp2),
    .stall_o      (stall)
  );
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WORD_SIZE, default 32: data width of every register and data port, in bits.
REQ-002 Parameter NUM_REGS, default 32: number of architectural registers; address width is 5 bits.
REQ-003 The clock port SHALL be: clk  input  1  rising-edge clock for all state.
REQ-004 The reset port SHALL be: reset  input  1  synchronous, active-high reset.
REQ-005 rs1, rs2  input  5  source addresses from the decode stage's decoded fields.
REQ-006 rd1_data, rd2_data  output  WORD_SIZE  read data for rs1 and rs2.
REQ-007 wr_en  input  1  writeback strobe.
REQ-008 wr_addr  input  5  writeback register address.
REQ-009 wr_data  input  WORD_SIZE  writeback data.
REQ-010 alloc_valid  input  1  the issuing instruction will write rd_alloc.
REQ-011 rd_alloc  input  5  destination register of the issuing instruction.
REQ-012 stall  output  1  hazard; issue SHALL hold this cycle.

Function
REQ-013 Reads SHALL be combinational, with zero cycles of latency; writes SHALL commit on the clk rising edge when wr_en=1.
REQ-014 Register x0 SHALL always read 0; writes to it are dropped; it is never marked busy.
REQ-015 Scoreboard: the block SHALL keep one busy bit per register, all cleared at reset.
REQ-016 At a clock edge with alloc_valid=1, stall=0 and rd_alloc!=0, the block SHALL set busy[rd_alloc].
REQ-017 At a clock edge with wr_en=1 and wr_addr!=0, the block SHALL clear busy[wr_addr].
REQ-018 When set and clear hit the same register in the same cycle, set SHALL win.
REQ-019 stall SHALL be 1 when rs1 or rs2 is busy and not satisfied by a same-cycle writeback.
REQ-020 stall SHALL also be 1 on WAW: alloc_valid=1 with busy[rd_alloc]=1 and no same-cycle writeback to it.
REQ-021 While stall=1, alloc_valid SHALL be ignored; writeback SHALL proceed normally.
REQ-022 Writeback to a register that is not busy SHALL be legal: data is written and busy stays 0.
REQ-023 An alloc issued while stall=0 SHALL take effect even if the producing writeback arrives the very next cycle.

Reset
REQ-024 On reset=1 at a clk edge, all registers SHALL clear to 0 and all busy bits SHALL clear to 0.
REQ-025 During reset, wr_en and alloc_valid SHALL be ignored; reset asserted mid-hazard SHALL drop stall the cycle after.
REQ-026 Outputs immediately after reset: rd1_data=rd2_data=0 and stall=0.

Configuration
REQ-027 The macro REGFILE_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-028 With REGFILE_BYPASS_EN defined: if wr_en=1, wr_addr!=0 and wr_addr equals rsN, rdN_data SHALL equal wr_data in the same cycle, and that writeback SHALL satisfy the rsN busy check for stall.
REQ-029 With REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge contents, a same-cycle writeback SHALL NOT clear stall, and the consumer stalls one extra cycle.

Structure
REQ-030 WORD_SIZE, NUM_REGS, the register-address type and the x0 index constant SHALL live in a shared package, replacing the per-file defines.
REQ-031 The scoreboard SHALL be one sub-module, reg_scoreboard: busy vector plus stall logic, with the bypass match supplied as an input.
REQ-032 The storage array SHALL remain in register_file.

Verification
REQ-033 Reset, then read x0..x31 -> all 0 and stall=0.
REQ-034 Write x5=0xDEADBEEF, then next cycle rs1=5 -> rd1_data=0xDEADBEEF; write x0=0x1234 -> rs2=0 reads 0.
REQ-035 Alloc x7; next cycle rs1=7 with no writeback -> stall=1 and alloc of x9 ignored; writeback x7=0x55 -> busy[7]=0; with BYPASS_EN stall=0 in that same cycle, without it stall=0 the cycle after.
REQ-036 With BYPASS_EN: wr_en=1, wr_addr=3, wr_data=0xA5A5A5A5 while rs1=rs2=3 -> both read 0xA5A5A5A5 the same cycle.
REQ-037 x4 busy, then alloc x4 and writeback x4 in the same cycle -> stall=0 and busy[4]=1 after the edge (set wins); then alloc x4 again with no writeback -> stall=1 (WAW).
REQ-038 Busy x10 and x11 set, then reset asserted for one cycle -> all busy bits 0, stall=0, x10 reads 0.
